hdmi_audio_scheduler: RTL

// - Paces stereo audio samples into the HDMI encoder's audio port.
// - Produces the ~48 kHz clk_audio from the pixel clock with a fractional phase accumulator.
// - Buffers producer samples (SID/mixer, bursty, any rate) in a small FIFO.
// - Presents one sample per audio period, stable across the rising edge of clk_audio.
// - Sits between the audio source and the hdmi encoder inside the video top.

---
 rtl/hdmi_audio_scheduler_pkg.sv | 20 ++
 rtl/hdmi_audio_scheduler_sync_fifo.sv | 63 ++++++
 rtl/hdmi_audio_scheduler.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/hdmi_audio_scheduler_pkg.sv
// Shared types, default rate constants and sizing helpers for the HDMI audio scheduler.
package hdmi_audio_scheduler_pkg;

    typedef enum logic {
        ST_PREFILL = 1'b0,
        ST_RUN     = 1'b1
    } state_t;

    localparam int unsigned DEF_CLK_HZ     = 31488000;
    localparam int unsigned DEF_SAMPLE_HZ  = 48000;
    localparam int unsigned DEF_WIDTH      = 16;
    localparam int unsigned DEF_FIFO_DEPTH = 8;
    localparam int unsigned DEF_PREFILL    = 4;

    // Occupancy counter width: must hold the value DEPTH itself.
    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/hdmi_audio_scheduler_sync_fifo.sv
// Single-clock FIFO with occupancy counter; push is ignored when full, pop when empty.
module sync_fifo
    import hdmi_audio_scheduler_pkg::*;
#(
    parameter int unsigned W     = 32,
    parameter int unsigned DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       i_push,
    input  logic [W-1:0]               i_data,
    input  logic                       i_pop,
    output logic [W-1:0]               o_data,
    output logic                       o_full,
    output logic                       o_empty,
    output logic [level_w(DEPTH)-1:0]  o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [LW-1:0] r_level;
    logic          w_push_ok;
    logic          w_pop_ok;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign o_level   = r_level;
    assign o_data    = r_mem[r_rd_ptr];
    assign w_push_ok = i_push & ~o_full;
    assign w_pop_ok  = i_pop & ~o_empty;

    // Storage carries no reset; only pointers and the level define validity.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_mem[r_wr_ptr] <= i_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            case ({w_push_ok, w_pop_ok})
                2'b10:   r_level <= r_level + 1'b1;
                2'b01:   r_level <= r_level - 1'b1;
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/hdmi_audio_scheduler.sv
// Paces buffered stereo samples onto the HDMI audio port at SAMPLE_HZ, deriving a
// 50% duty clk_audio from the pixel clock with a drift-free fractional accumulator.
module hdmi_audio_scheduler
    import hdmi_audio_scheduler_pkg::*;
#(
    parameter int unsigned CLK_HZ     = DEF_CLK_HZ,
    parameter int unsigned SAMPLE_HZ  = DEF_SAMPLE_HZ,
    parameter int unsigned WIDTH      = DEF_WIDTH,
    parameter int unsigned FIFO_DEPTH = DEF_FIFO_DEPTH,
    parameter int unsigned PREFILL    = DEF_PREFILL
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic [WIDTH-1:0]                   in_l,
    input  logic [WIDTH-1:0]                   in_r,
    input  logic                               in_valid,
    output logic                               in_ready,
    input  logic                               mute,
    output logic                               clk_audio,
    output logic [WIDTH-1:0]                   audio_l,
    output logic [WIDTH-1:0]                   audio_r,
    output logic                               sample_tick,
    output logic                               underrun,
    output logic [level_w(FIFO_DEPTH)-1:0]     fifo_level,
    output state_t                             dbg_state
);

    localparam int unsigned LW    = level_w(FIFO_DEPTH);
    localparam logic [32:0] INC   = 33'(2 * SAMPLE_HZ);
    localparam logic [32:0] CLK33 = 33'(CLK_HZ);

    if (CLK_HZ <= 2 * SAMPLE_HZ) begin : g_bad_rate
        $error("hdmi_audio_scheduler: CLK_HZ must exceed 2*SAMPLE_HZ");
    end
    if ((FIFO_DEPTH < 2) || ((FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)) begin : g_bad_depth
        $error("hdmi_audio_scheduler: FIFO_DEPTH must be a power of 2 and >= 2");
    end
    if ((PREFILL < 1) || (PREFILL > FIFO_DEPTH)) begin : g_bad_prefill
        $error("hdmi_audio_scheduler: PREFILL must be in 1..FIFO_DEPTH");
    end

    logic [31:0]        r_acc;
    logic               r_clk_audio;
    logic [WIDTH-1:0]   r_audio_l;
    logic [WIDTH-1:0]   r_audio_r;
    logic               r_sample_tick;
    logic               r_underrun;
    state_t             r_state;

    logic [32:0]        w_sum;
    logic [31:0]        w_acc_next;
    logic               w_half;
    logic               w_slot;
    state_t             w_state_next;
    logic               w_push;
    logic               w_pop;
    logic               w_underrun;
    logic               w_fifo_full;
    logic               w_fifo_empty;
    logic [LW-1:0]      w_level;
    logic [2*WIDTH-1:0] w_fifo_rdata;

    // Phase accumulator: each wrap past CLK_HZ is one half-period of clk_audio.
    assign w_sum      = {1'b0, r_acc} + INC;
    assign w_half     = (w_sum >= CLK33);
    assign w_acc_next = w_half ? 32'(w_sum - CLK33) : 32'(w_sum);
    // Samples move on the falling edge so they are settled half a period before the encoder latches.
    assign w_slot     = w_half & r_clk_audio;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc       <= '0;
            r_clk_audio <= 1'b0;
        end else begin
            r_acc <= w_acc_next;
            if (w_half) begin
                r_clk_audio <= ~r_clk_audio;
            end
        end
    end

    // Producer handshake: a pair transfers on any clk where in_valid and in_ready are both high;
    // in_valid may assert freely, in_ready depends only on FIFO fullness and reset.
    assign in_ready = ~w_fifo_full & ~reset;
    assign w_push   = in_valid & in_ready;

    sync_fifo #(
        .W     (2 * WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .reset   (reset),
        .i_push  (w_push),
        .i_data  ({in_l, in_r}),
        .i_pop   (w_pop),
        .o_data  (w_fifo_rdata),
        .o_full  (w_fifo_full),
        .o_empty (w_fifo_empty),
        .o_level (w_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_PREFILL;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_PREFILL: begin
                if (w_level >= LW'(PREFILL)) begin
                    w_state_next = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_slot && w_fifo_empty) begin
                    w_state_next = ST_PREFILL;
                end
            end
            default: w_state_next = ST_PREFILL;
        endcase
    end

    // A pair pushed into an empty FIFO during a slot is not visible to that slot's pop.
    always_comb begin
        w_pop      = 1'b0;
        w_underrun = 1'b0;
        if ((r_state == ST_RUN) && w_slot) begin
            if (!w_fifo_empty) begin
                w_pop = 1'b1;
            end else begin
                w_underrun = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_audio_l     <= '0;
            r_audio_r     <= '0;
            r_sample_tick <= 1'b0;
            r_underrun    <= 1'b0;
        end else begin
            r_sample_tick <= w_slot;
            r_underrun    <= w_underrun;
            if (w_pop) begin
                r_audio_l <= mute ? '0 : w_fifo_rdata[2*WIDTH-1:WIDTH];
                r_audio_r <= mute ? '0 : w_fifo_rdata[WIDTH-1:0];
            end
        end
    end

    assign clk_audio   = r_clk_audio;
    assign audio_l     = r_audio_l;
    assign audio_r     = r_audio_r;
    assign sample_tick = r_sample_tick;
    assign underrun    = r_underrun;
    assign fifo_level  = w_level;
    assign dbg_state   = r_state;

endmodule
